// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops 0..6; MUL is an iterative shift-add taking WIDTH cycles.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mul_sum;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   wide;
    logic [SW-1:0]    amt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == EXEC);
    assign accept    = in_valid & in_ready;
    assign last_iter = (cnt == LAST);
    assign mul_sum   = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (op == OP_MUL) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifts use a WIDTH+1 window so the extra bit catches the last bit shifted out.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        wide    = '0;
        amt     = b[SW-1:0];
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_SUB: begin
                wide    = {1'b0, a} - {1'b0, b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (wide[MSB] != a[MSB]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_SHL: begin
                wide    = {1'b0, a} << amt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {a, 1'b0} >> amt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= '0;
                        end else begin
                            result <= alu_res;
                            flags  <= {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
                        end
                    end
                end
                // One multiplier bit per cycle; the final add lands straight in the result.
                EXEC: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        result <= mul_sum[WIDTH-1:0];
                        flags  <= {(mul_sum[WIDTH-1:0] == '0), mul_sum[MSB],
                                   (mul_sum[2*WIDTH-1:WIDTH] != '0),
                                   (mul_sum[2*WIDTH-1:WIDTH] != '0)};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed vectors push expectations,
// an independent monitor pops and compares on every output transfer.
module tb_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got result 0x%0h flags 0x%0h, expected no output", result, flags);
            end else begin
                cur = expq.pop_front();
                checkOutput({cur.name, "_result"}, 32'(result), 32'(cur.res));
                checkOutput({cur.name, "_flags"}, 32'(flags), 32'(cur.flg));
            end
        end
    end

    task automatic waitReady(input string name, output bit ok);
        int waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: in_ready stayed 0, expected 1 within 50 cycles", name);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] vop, input logic [7:0] va,
                                 input logic [7:0] vb, input logic [7:0] eres, input logic [3:0] eflg,
                                 input int elat, input int ebusy);
        bit ok;
        int lat;
        int busyc;
        exp_t e;
        waitReady(name, ok);
        if (!ok) return;
        in_valid = 1'b1;
        op       = vop;
        a        = va;
        b        = vb;
        e.name   = name;
        e.res    = eres;
        e.flg    = eflg;
        expq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 1;
        busyc    = 0;
        while (!out_valid && lat < 50) begin
            if (busy) busyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'(elat));
        checkOutput({name, "_busy_cycles"}, 32'(busyc), 32'(ebusy));
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // Flags are {Z,N,C,V}.
        applyStimulus("add_255_1",   3'd0, 8'd255, 8'd1,   8'd0,   4'b1010, 1, 0);
        applyStimulus("add_120_11",  3'd0, 8'd120, 8'd11,  8'd131, 4'b0101, 1, 0);
        applyStimulus("sub_0_255",   3'd1, 8'd0,   8'd255, 8'd1,   4'b0010, 1, 0);
        applyStimulus("sub_100_100", 3'd1, 8'd100, 8'd100, 8'd0,   4'b1000, 1, 0);
        applyStimulus("and_cc_aa",   3'd2, 8'hCC,  8'hAA,  8'h88,  4'b0100, 1, 0);
        applyStimulus("or_00_00",    3'd3, 8'h00,  8'h00,  8'h00,  4'b1000, 1, 0);
        applyStimulus("shl_81_1",    3'd5, 8'h81,  8'd1,   8'h02,  4'b0010, 1, 0);
        applyStimulus("shr_81_9",    3'd6, 8'h81,  8'd9,   8'h40,  4'b0010, 1, 0);
        applyStimulus("shl_5a_0",    3'd5, 8'h5A,  8'd0,   8'h5A,  4'b0000, 1, 0);
        applyStimulus("shr_80_7",    3'd6, 8'h80,  8'd7,   8'h01,  4'b0000, 1, 0);
        applyStimulus("mul_15_17",   3'd7, 8'd15,  8'd17,  8'd255, 4'b0100, 9, 8);
        applyStimulus("mul_16_16",   3'd7, 8'd16,  8'd16,  8'd0,   4'b1011, 9, 8);
        applyStimulus("mul_255_255", 3'd7, 8'd255, 8'd255, 8'h01,  4'b0011, 9, 8);

        // Backpressure: result must hold and new requests must be dropped.
        waitReady("bp_pre", ok);
        out_ready = 1'b0;
        applyStimulus("xor_f0_ff",   3'd4, 8'hF0,  8'hFF,  8'h0F,  4'b0000, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_result_hold", 32'(result), 32'h0F);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            op       = 3'd0;
            a        = 8'd1;
            b        = 8'd1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        checkOutput("bp_out_valid_held", 32'(out_valid), 32'd1);
        checkOutput("bp_flags_hold", 32'(flags), 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_in_ready_after", 32'(in_ready), 32'd1);
        checkOutput("bp_out_valid_after", 32'(out_valid), 32'd0);

        // Reset in the middle of MUL 200*3: nothing from it may ever appear.
        waitReady("rst_mul", ok);
        if (ok) begin
            in_valid = 1'b1;
            op       = 3'd7;
            a        = 8'd200;
            b        = 8'd3;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            checkOutput("rst_mul_busy_before", 32'(busy), 32'd1);
            rst = 1'b1;
            #1;
            checkOutput("rst_mul_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_mul_busy", 32'(busy), 32'd0);
            checkOutput("rst_mul_result", 32'(result), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        applyStimulus("add_1_2",     3'd0, 8'd1,   8'd2,   8'd3,   4'b0000, 1, 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
